mhsa_seq_ctrl: RTL and testbench
================================

// Module: mhsa_seq_ctrl
// PURPOSE
//  Sequencer for one MHSA job. Sits between the ICB interface unit's CSRs (start/input_base/output_base/done)
//  and the shared 64-bit usram / compute engine. On start it streams LOAD_WORDS words from usram[input_base..]
//  into the engine, waits for engine completion, writes STORE_WORDS result words to usram[output_base..],
//  then pulses done. While busy it owns the usram port; host access is reported as blocked.
// PARAMETERS
//  DATA_W       64   usram / engine data width
//  UADDR_W      14   usram word-address width (0x0000..0x3FFF)
//  LOAD_WORDS   64   words fetched per job (>=1)
//  STORE_WORDS  64   words written back per job (>=1)
// PORTS
//  clk           in   1        clock; single clock domain
//  rst_n         in   1        asynchronous active-low reset
//  start         in   32       CSR; bit0 = go (rising edge), bit1 = abort (level)
//  input_base    in   32       CSR; usram word address of first input word (low UADDR_W bits used)
//  output_base   in   32       CSR; usram word address of first output word (low UADDR_W bits used)
//  done_set      out  1        1-cycle pulse at job completion (CSR done <= 1)
//  busy          out  1        1 in any state except IDLE
//  host_blocked  out  1        = busy; ICB usram accesses must be held/ignored
//  usram_addr    out  UADDR_W  usram word address
//  usram_rd_en   out  1        read strobe; rdata valid exactly 1 cycle later
//  usram_rdata   in   DATA_W   read data
//  usram_wr_en   out  1        write strobe (addr/wdata valid same cycle)
//  usram_wdata   out  DATA_W   write data
//  eng_start     out  1        1-cycle pulse on leaving IDLE
//  eng_in_valid  out  1        input word valid to engine
//  eng_in_data   out  DATA_W   input word
//  eng_in_ready  in   1        engine accepts input word
//  eng_done      in   1        engine finished compute (level or pulse, sampled in WAIT)
//  eng_out_valid in   1        engine result word valid
//  eng_out_data  in   DATA_W   result word
//  eng_out_ready out  1        = (state==STORE)
// BEHAVIOUR
//  Reset (async): state=IDLE, counters=0, all outputs 0.
//  FSM: IDLE -> RD -> HOLD -> (RD | WAIT) -> STORE -> FIN -> IDLE.
//  IDLE: go = start[0] & !start_q (start_q registered). On go: eng_start=1 one cycle, ld_cnt=0, -> RD.
//  RD: usram_rd_en=1, usram_addr=(input_base+ld_cnt) mod 2^UADDR_W; -> HOLD next cycle.
//  HOLD: capture usram_rdata into data reg on entry; eng_in_valid=1 until eng_in_ready.
//   On handshake: ld_cnt++; if ld_cnt==LOAD_WORDS-1 -> WAIT else -> RD. (>=2 cycles/word.)
//  WAIT: eng_done=1 -> STORE, st_cnt=0. Engine output valid before STORE is not accepted.
//  STORE: eng_out_ready=1; on eng_out_valid: usram_wr_en=1 same cycle,
//   usram_addr=(output_base+st_cnt) mod 2^UADDR_W, usram_wdata=eng_out_data, st_cnt++;
//   after word STORE_WORDS-1 -> FIN.
//  FIN: done_set=1 for exactly one cycle -> IDLE.
//  usram_rd_en and usram_wr_en never both 1; usram_addr=0 when neither strobe is set.
//  Address arithmetic: 32-bit add truncated to UADDR_W, so it wraps 0x3FFF -> 0x0000.
//  A go edge while busy is ignored (not queued). start[0] held high does not retrigger; it must return to 0 first.
//  Abort (start[1]=1) in any non-IDLE state: -> IDLE next cycle; no done_set; strobes are 0 that cycle;
//   counters are cleared. Abort beats go when both are seen in the same cycle.
//  Base CSRs are sampled live. Software must not change them while busy.
//  Reset mid-job: immediate IDLE; no done_set and no further usram strobes.
// TESTING
//  1 Reset: assert rst_n=0 mid-STORE -> all outputs 0 asynchronously; after release, busy=0 and no strobes.
//  2 Full job, LOAD_WORDS=STORE_WORDS=4, input_base=0x10, output_base=0x200, eng_in_ready=1:
//    reads 0x10..0x13 -> 4 eng_in handshakes; writes 0x200..0x203; one done_set.
//  3 Backpressure: eng_in_ready low for 5 cycles on word 2 -> eng_in_data stable, no extra rd_en, order preserved.
//  4 Wrap: input_base=0x3FFE, 4 words -> read addrs 0x3FFE, 0x3FFF, 0x0000, 0x0001.
//  5 Retrigger/abort: go pulse during WAIT -> ignored, single done_set; start[1]=1 in STORE -> IDLE, no done_set.
//  6 Gapped output: eng_out_valid toggling 1,0,0,1 -> wr_en only on valid cycles, addresses consecutive.

Source files
------------

// File: rtl/mhsa_seq_ctrl.sv
// MHSA job sequencer: streams usram words into the engine,
// waits for compute, writes results back, then flags done.
module mhsa_seq_ctrl #(
  parameter int DATA_W      = 64,
  parameter int UADDR_W     = 14,
  parameter int LOAD_WORDS  = 64,
  parameter int STORE_WORDS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        start,
  input  logic [31:0]        input_base,
  input  logic [31:0]        output_base,
  output logic               done_set,
  output logic               busy,
  output logic               host_blocked,
  output logic [UADDR_W-1:0] usram_addr,
  output logic               usram_rd_en,
  input  logic [DATA_W-1:0]  usram_rdata,
  output logic               usram_wr_en,
  output logic [DATA_W-1:0]  usram_wdata,
  output logic               eng_start,
  output logic               eng_in_valid,
  output logic [DATA_W-1:0]  eng_in_data,
  input  logic               eng_in_ready,
  input  logic               eng_done,
  input  logic               eng_out_valid,
  input  logic [DATA_W-1:0]  eng_out_data,
  output logic               eng_out_ready
);

  localparam int LCW = $clog2(LOAD_WORDS + 1);
  localparam int SCW = $clog2(STORE_WORDS + 1);
  localparam logic [LCW-1:0] LD_LAST = LCW'(LOAD_WORDS - 1);
  localparam logic [SCW-1:0] ST_LAST = SCW'(STORE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_HOLD,
    S_WAIT,
    S_STORE,
    S_FIN
  } state_e;

  state_e             state_q, state_d;
  logic               start_q;
  logic [LCW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [SCW-1:0]     st_cnt_q, st_cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               first_q, first_d;
  logic               eng_start_q, eng_start_d;

  logic               go;
  logic               abort;
  logic [31:0]        rd_sum;
  logic [31:0]        wr_sum;
  logic               unused_bits;

  assign go    = start[0] & ~start_q;
  assign abort = start[1];

  // 32-bit sums; only the low UADDR_W bits address usram
  assign rd_sum = input_base + 32'(ld_cnt_q);
  assign wr_sum = output_base + 32'(st_cnt_q);

  assign unused_bits = ^{start[31:2],
                         rd_sum[31:UADDR_W],
                         wr_sum[31:UADDR_W]};

  assign busy          = (state_q != S_IDLE);
  assign host_blocked  = busy;
  assign eng_out_ready = (state_q == S_STORE);
  assign eng_start     = eng_start_q;

  // state, counters, captured read word, start edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      ld_cnt_q    <= '0;
      st_cnt_q    <= '0;
      data_q      <= '0;
      first_q     <= 1'b0;
      eng_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start[0];
      ld_cnt_q    <= ld_cnt_d;
      st_cnt_q    <= st_cnt_d;
      data_q      <= data_d;
      first_q     <= first_d;
      eng_start_q <= eng_start_d;
    end
  end

  // next-state and strobes; abort overrides everything
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    st_cnt_d    = st_cnt_q;
    data_d      = data_q;
    first_d     = 1'b0;
    eng_start_d = 1'b0;
    done_set    = 1'b0;
    usram_rd_en = 1'b0;
    usram_wr_en = 1'b0;
    usram_addr  = '0;
    usram_wdata = '0;
    eng_in_valid = 1'b0;
    eng_in_data  = '0;
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      ld_cnt_d = '0;
      st_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go && !abort) begin
            eng_start_d = 1'b1;
            ld_cnt_d    = '0;
            state_d     = S_RD;
          end
        end
        S_RD: begin
          usram_rd_en = 1'b1;
          usram_addr  = rd_sum[UADDR_W-1:0];
          first_d     = 1'b1;
          state_d     = S_HOLD;
        end
        S_HOLD: begin
          // read data is only on the bus in the first HOLD cycle
          eng_in_valid = 1'b1;
          eng_in_data  = first_q ? usram_rdata : data_q;
          if (first_q) begin
            data_d = usram_rdata;
          end
          if (eng_in_ready) begin
            ld_cnt_d = ld_cnt_q + 1'b1;
            state_d  = (ld_cnt_q == LD_LAST) ? S_WAIT : S_RD;
          end
        end
        S_WAIT: begin
          if (eng_done) begin
            st_cnt_d = '0;
            state_d  = S_STORE;
          end
        end
        S_STORE: begin
          if (eng_out_valid) begin
            usram_wr_en = 1'b1;
            usram_addr  = wr_sum[UADDR_W-1:0];
            usram_wdata = eng_out_data;
            st_cnt_d    = st_cnt_q + 1'b1;
            if (st_cnt_q == ST_LAST) begin
              state_d = S_FIN;
            end
          end
        end
        S_FIN: begin
          done_set = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mhsa_seq_ctrl.sv
// Scoreboard bench for mhsa_seq_ctrl with a usram model,
// a behavioural engine and a job-level reference model.
module tb_mhsa_seq_ctrl;

  localparam int DW = 64;
  localparam int AW = 14;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   start, input_base, output_base;
  logic          done_set, busy, host_blocked;
  logic [AW-1:0] usram_addr;
  logic          usram_rd_en, usram_wr_en;
  logic [DW-1:0] usram_rdata, usram_wdata;
  logic          eng_start, eng_in_valid, eng_in_ready;
  logic [DW-1:0] eng_in_data, eng_out_data;
  logic          eng_done, eng_out_valid, eng_out_ready;

  mhsa_seq_ctrl #(
    .DATA_W(DW), .UADDR_W(AW),
    .LOAD_WORDS(NW), .STORE_WORDS(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .input_base(input_base), .output_base(output_base),
    .done_set(done_set), .busy(busy),
    .host_blocked(host_blocked),
    .usram_addr(usram_addr), .usram_rd_en(usram_rd_en),
    .usram_rdata(usram_rdata), .usram_wr_en(usram_wr_en),
    .usram_wdata(usram_wdata), .eng_start(eng_start),
    .eng_in_valid(eng_in_valid), .eng_in_data(eng_in_data),
    .eng_in_ready(eng_in_ready), .eng_done(eng_done),
    .eng_out_valid(eng_out_valid),
    .eng_out_data(eng_out_data),
    .eng_out_ready(eng_out_ready)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:16383];

  int          exp_rd[$];
  logic [63:0] exp_in[$];
  int          exp_wa[$];
  logic [63:0] exp_wd[$];
  int          exp_start[$];
  int          exp_done[$];

  int vectors = 0;
  int miscompares = 0;

  int          in_mode = 0, out_mode = 0, done_delay = 0;
  logic [63:0] job_res [NW];
  int          e_in_cnt = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event, value %h", nm, act);
  endtask

  task automatic flush_all();
    exp_rd.delete(); exp_in.delete();
    exp_wa.delete(); exp_wd.delete();
    exp_start.delete(); exp_done.delete();
  endtask

  // usram: registered read, garbage on cycles without a read
  initial begin
    logic          r;
    logic [AW-1:0] a;
    usram_rdata = '0;
    forever begin
      @(negedge clk);
      r = usram_rd_en;
      a = usram_addr;
      @(posedge clk); #1;
      usram_rdata = r ? mem[a] : {$urandom, $urandom};
    end
  end

  // behavioural engine
  initial begin
    logic s_start, s_in_hs, s_out_hs, v;
    int   out_idx, timer, stall, pat;
    out_idx = 0; timer = 0; stall = 0; pat = 0;
    eng_in_ready = 1'b0; eng_done = 1'b0;
    eng_out_valid = 1'b0; eng_out_data = '0;
    forever begin
      @(negedge clk);
      s_start  = eng_start;
      s_in_hs  = eng_in_valid && eng_in_ready;
      s_out_hs = eng_out_valid && eng_out_ready;
      if (eng_in_valid && !eng_in_ready) stall++;
      @(posedge clk); #1;
      if (s_start) begin
        e_in_cnt = 0; out_idx = 0; timer = 0;
        stall = 0; pat = 0; eng_done = 1'b0;
      end else begin
        if (s_in_hs) e_in_cnt++;
        if (s_out_hs) out_idx++;
      end
      case (in_mode)
        0: eng_in_ready = 1'b1;
        1: eng_in_ready = ($urandom_range(3) != 0);
        default: eng_in_ready = !(e_in_cnt == 2 && stall < 5);
      endcase
      if (e_in_cnt >= NW && !eng_done) begin
        if (timer >= done_delay) eng_done = 1'b1;
        else timer++;
      end
      if (eng_done && out_idx < NW) begin
        case (out_mode)
          0: v = 1'b1;
          1: v = 1'(($urandom_range(1)));
          default: v = (pat % 4 == 0) || (pat % 4 == 3);
        endcase
        pat++;
        eng_out_valid = v;
        eng_out_data  = job_res[out_idx];
      end else begin
        eng_out_valid = 1'b0;
        eng_out_data  = {$urandom, $urandom};
      end
    end
  end

  // monitor: pops expectations whenever the DUT acts
  initial begin
    logic        prev_stall;
    logic [63:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      chk("host_blocked", 64'(host_blocked), 64'(busy));
      chk("rd_wr_excl", 64'(usram_rd_en & usram_wr_en), 64'd0);
      if (!usram_rd_en && !usram_wr_en)
        chk("addr_idle", 64'(usram_addr), 64'd0);
      if (usram_rd_en) begin
        if (exp_rd.size() == 0) unexp("rd_addr", 64'(usram_addr));
        else chk("rd_addr", 64'(usram_addr), 64'(exp_rd.pop_front()));
      end
      if (prev_stall) begin
        chk("in_valid_held", 64'(eng_in_valid), 64'd1);
        chk("in_data_stable", eng_in_data, prev_data);
      end
      if (eng_in_valid && eng_in_ready) begin
        if (exp_in.size() == 0) unexp("in_data", eng_in_data);
        else chk("in_data", eng_in_data, exp_in.pop_front());
      end
      prev_stall = eng_in_valid && !eng_in_ready;
      prev_data  = eng_in_data;
      if (usram_wr_en) begin
        if (exp_wa.size() == 0) unexp("wr", 64'(usram_addr));
        else begin
          chk("wr_addr", 64'(usram_addr), 64'(exp_wa.pop_front()));
          chk("wr_data", usram_wdata, exp_wd.pop_front());
        end
        mem[usram_addr] = usram_wdata;
      end
      if (eng_start) begin
        if (exp_start.size() == 0) unexp("eng_start", 64'd1);
        else chk("eng_start", 64'(eng_start),
                 64'(exp_start.pop_front()));
      end
      if (done_set) begin
        if (exp_done.size() == 0) unexp("done_set", 64'd1);
        else chk("done_set", 64'(done_set),
                 64'(exp_done.pop_front()));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_queues(input string nm);
    chk({nm, "_rd_left"}, 64'(exp_rd.size()), 64'd0);
    chk({nm, "_wr_left"}, 64'(exp_wa.size()), 64'd0);
    chk({nm, "_done_left"}, 64'(exp_done.size()), 64'd0);
  endtask

  // act: 0 normal, 1 go during WAIT, 2 abort in STORE, 3 reset in STORE
  task automatic run_job(input string nm,
                         input logic [31:0] ib, ob,
                         input int im, om, dd, act);
    logic [63:0] sum;
    int          a, n;
    sum = '0;
    for (int i = 0; i < NW; i++) begin
      a = int'((ib + 32'(i)) & 32'h3FFF);
      exp_rd.push_back(a);
      exp_in.push_back(mem[a]);
      sum += mem[a];
    end
    for (int j = 0; j < NW; j++) begin
      job_res[j] = sum ^ (64'(j + 1) * 64'h9E37_79B9_7F4A_7C15);
      exp_wa.push_back(int'((ob + 32'(j)) & 32'h3FFF));
      exp_wd.push_back(job_res[j]);
    end
    exp_start.push_back(1);
    exp_done.push_back(1);
    input_base = ib; output_base = ob;
    in_mode = im; out_mode = om; done_delay = dd;
    @(posedge clk); #1;
    start = 32'h1;
    cycles($urandom_range(1, 3));
    start = 32'h0;
    n = 0;
    if (act == 1) begin
      while (!(e_in_cnt == NW && !eng_done) && n < 500) begin
        @(negedge clk); n++;
      end
      chk({nm, "_reach_wait"}, 64'(n < 500), 64'd1);
      @(posedge clk); #1;
      start = 32'h1;
      cycles(1);
      start = 32'h0;
    end else if (act >= 2) begin
      while (!(eng_out_ready && exp_wa.size() < NW) && n < 500) begin
        @(negedge clk); n++;
      end
      chk({nm, "_reach_store"}, 64'(n < 500), 64'd1);
      if (act == 2) begin
        @(posedge clk); #1;
        start = 32'h2;
        exp_wa.delete(); exp_wd.delete(); exp_done.delete();
        cycles(1);
        start = 32'h0;
        @(negedge clk);
        chk({nm, "_abort_busy"}, 64'(busy), 64'd0);
      end else begin
        #2 rst_n = 1'b0;
        #1;
        chk({nm, "_rst_ctl"},
            64'({busy, host_blocked, done_set, usram_rd_en,
                 usram_wr_en, eng_start, eng_in_valid,
                 eng_out_ready, usram_addr}), 64'd0);
        chk({nm, "_rst_data"}, usram_wdata | eng_in_data, 64'd0);
        flush_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({nm, "_post_rst_busy"}, 64'(busy), 64'd0);
      end
    end
    n = 0;
    while (exp_done.size() != 0 && n < 1000) begin
      @(negedge clk); n++;
    end
    chk({nm, "_timeout"}, 64'(exp_done.size()), 64'd0);
    flush_all();
    cycles(act == 0 ? 3 : 20);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
    check_queues(nm);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = {$urandom, $urandom};
    rst_n = 1'b0;
    start = '0; input_base = '0; output_base = '0;
    cycles(3);
    chk("reset_ctl",
        64'({busy, host_blocked, done_set, usram_rd_en,
             usram_wr_en, eng_start, eng_in_valid,
             eng_out_ready, usram_addr}), 64'd0);
    chk("reset_data", usram_wdata | eng_in_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    chk("reset_busy", 64'(busy), 64'd0);

    run_job("full", 32'h10, 32'h200, 0, 0, 2, 0);
    run_job("bp", 32'h40, 32'h300, 2, 0, 1, 0);
    run_job("wrap", 32'h3FFE, 32'h3FFD, 0, 1, 0, 0);
    run_job("gap", 32'h123, 32'h800, 1, 2, 3, 0);
    run_job("retrig", 32'h500, 32'h900, 0, 0, 12, 1);
    run_job("abort", 32'h600, 32'hA00, 0, 0, 2, 2);

    // abort and go together in IDLE: no job starts
    @(posedge clk); #1;
    start = 32'h3;
    cycles(1);
    start = 32'h0;
    cycles(6);
    chk("abort_beats_go", 64'(busy), 64'd0);

    run_job("rst_store", 32'h700, 32'hB00, 0, 0, 2, 3);
    run_job("after_rst", 32'h20, 32'h220, 0, 0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      run_job("rand", $urandom, $urandom,
              $urandom_range(2), $urandom_range(2),
              $urandom_range(6), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
